// File: rtl/uart_frame_sched.sv
// -----------------------------------------------------------------------------
// uart_frame_sched
//
// Shares one uart_tx byte transmitter between the ADC sample FIFO and a status
// word source. Each granted word is wrapped in a framed packet
// {SYNC, hi byte, lo byte} and sent byte by byte using uart_tx's start/int
// handshake. When both sources are pending, round-robin arbitration hands the
// transmitter to the source that was not granted last.
//
// Optional build macro: SCHED_CHECKSUM_EN
//   When defined, every frame carries a 4th byte, the XOR of bytes 0..2.
//   When undefined, frames are 3 bytes and no checksum logic exists.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset (all outputs 0, state IDLE)
//   en               1 = new frames may start; 0 = finish current frame, then idle
//   fifo_empty_i     sample FIFO empty
//   fifo_rd_en_o     one-cycle FIFO read pulse (FIFO read latency 1 cycle)
//   fifo_data_i      FIFO read data, valid the cycle after fifo_rd_en_o
//   stat_req_i       status frame requested (level, held until stat_ack_o)
//   stat_data_i      status word, sampled in the cycle stat_ack_o is high
//   stat_ack_o       one-cycle pulse: status word consumed
//   uart_tx_start_o  one-cycle start pulse to uart_tx
//   uart_tx_data_o   byte to send, stable from start pulse until uart_tx_int_i
//   uart_tx_int_i    one-cycle byte-done pulse from uart_tx
//   busy_o           1 whenever the scheduler is not idle
//   frame_cnt_o      completed frames (both kinds), wraps to 0
//   timeout_err_o    sticky: a frame was aborted on timeout; cleared only by rst
// -----------------------------------------------------------------------------
module uart_frame_sched #(
    parameter int         DATA_W      = 13,
    parameter logic [7:0] SYNC_SMP    = 8'hA5,
    parameter logic [7:0] SYNC_STAT   = 8'h5A,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              stat_req_i,
    input  logic [15:0]       stat_data_i,
    output logic              stat_ack_o,
    output logic              uart_tx_start_o,
    output logic [7:0]        uart_tx_data_o,
    input  logic              uart_tx_int_i,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o,
    output logic              timeout_err_o
);

`ifdef SCHED_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    localparam logic [1:0]       LAST_IDX = 2'(NB - 1);
    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

`ifdef SCHED_CHECKSUM_EN
    // Frame check byte: XOR of sync, hi and lo bytes.
    function automatic logic [7:0] frame_xor(input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
        frame_xor = b0 ^ b1 ^ b2;
    endfunction
`endif

    state_t           state_r;
    state_t           state_nx_s;
    logic             grant_smp_r;      // 1 = current frame is a sample frame
    logic             grant_smp_nx_s;
    logic             last_stat_r;      // 1 = status was granted last
    logic             last_stat_nx_s;
    logic [1:0]       idx_r;            // index of the byte currently on the wire
    logic [1:0]       idx_nx_s;
    logic [TMO_W-1:0] tmo_r;
    logic [TMO_W-1:0] tmo_nx_s;
    logic [7:0]       tx_data_nx_s;
    logic             abort_s;
    logic [15:0]      word_s;
    logic [7:0]       sync_s;
    logic [7:0]       frame_r [NB];

    // Word and sync byte of the frame being loaded, selected by the grant.
    always_comb begin
        word_s = 16'd0;
        sync_s = 8'd0;
        if (grant_smp_r) begin
            word_s = 16'(fifo_data_i);
            sync_s = SYNC_SMP;
        end else begin
            word_s = stat_data_i;
            sync_s = SYNC_STAT;
        end
    end

    // Next-state, arbitration, byte sequencing and WAIT timeout.
    always_comb begin
        state_nx_s     = state_r;
        grant_smp_nx_s = grant_smp_r;
        last_stat_nx_s = last_stat_r;
        idx_nx_s       = idx_r;
        tmo_nx_s       = {TMO_W{1'b0}};
        tx_data_nx_s   = uart_tx_data_o;
        abort_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && !fifo_empty_i && stat_req_i) begin
                    // Contest: the side that lost last time wins now.
                    grant_smp_nx_s = last_stat_r;
                    last_stat_nx_s = !last_stat_r;
                    state_nx_s     = last_stat_r ? ST_FETCH : ST_LOAD;
                end else if (en && !fifo_empty_i) begin
                    grant_smp_nx_s = 1'b1;
                    last_stat_nx_s = 1'b0;
                    state_nx_s     = ST_FETCH;
                end else if (en && stat_req_i) begin
                    grant_smp_nx_s = 1'b0;
                    last_stat_nx_s = 1'b1;
                    state_nx_s     = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nx_s = ST_LOAD;
            end
            ST_LOAD: begin
                // Byte 0 is the sync constant, so it can be driven before
                // the frame buffer is written at the end of this cycle.
                idx_nx_s     = 2'd0;
                tx_data_nx_s = sync_s;
                state_nx_s   = ST_START;
            end
            ST_START: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (uart_tx_int_i) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        idx_nx_s     = idx_r + 2'd1;
                        tx_data_nx_s = frame_r[idx_r + 2'd1];
                        state_nx_s   = ST_START;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    tmo_nx_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control state and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            grant_smp_r     <= 1'b0;
            last_stat_r     <= 1'b1;
            idx_r           <= 2'd0;
            tmo_r           <= {TMO_W{1'b0}};
            fifo_rd_en_o    <= 1'b0;
            stat_ack_o      <= 1'b0;
            uart_tx_start_o <= 1'b0;
            uart_tx_data_o  <= 8'd0;
            busy_o          <= 1'b0;
            frame_cnt_o     <= 16'd0;
            timeout_err_o   <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            grant_smp_r     <= grant_smp_nx_s;
            last_stat_r     <= last_stat_nx_s;
            idx_r           <= idx_nx_s;
            tmo_r           <= tmo_nx_s;
            // Outputs are decoded from the next state so they line up with it.
            fifo_rd_en_o    <= (state_nx_s == ST_FETCH);
            stat_ack_o      <= (state_nx_s == ST_LOAD) && !grant_smp_nx_s;
            uart_tx_start_o <= (state_nx_s == ST_START);
            uart_tx_data_o  <= tx_data_nx_s;
            busy_o          <= (state_nx_s != ST_IDLE);
            if (state_r == ST_DONE) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end else begin
                frame_cnt_o <= frame_cnt_o;
            end
            if (abort_s) begin
                timeout_err_o <= 1'b1;
            end else begin
                timeout_err_o <= timeout_err_o;
            end
        end
    end

    // Frame byte buffer, captured once per frame in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                frame_r[i] <= 8'd0;
            end
        end else if (state_r == ST_LOAD) begin
            frame_r[0] <= sync_s;
            frame_r[1] <= word_s[15:8];
            frame_r[2] <= word_s[7:0];
`ifdef SCHED_CHECKSUM_EN
            frame_r[3] <= frame_xor(sync_s, word_s[15:8], word_s[7:0]);
`endif
        end else begin
            for (int i = 0; i < NB; i++) begin
                frame_r[i] <= frame_r[i];
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_sched
//
// Scoreboard bench for uart_frame_sched. Stimulus tasks push the bytes each
// frame must produce into exp_q; a monitor pops and compares on every
// uart_tx_start_o pulse. Small behavioural models stand in for the sample
// FIFO (1-cycle read latency) and uart_tx (byte done 4 cycles after start).
// DUT runs with TIMEOUT_CYC = 16 so the abort path is reachable quickly.
// -----------------------------------------------------------------------------
module tb_uart_frame_sched;

    localparam int DATA_W = 13;

    logic              clk;
    logic              rst;
    logic              en;
    logic              fifo_empty_i;
    logic              fifo_rd_en_o;
    logic [DATA_W-1:0] fifo_data_i;
    logic              stat_req_i;
    logic [15:0]       stat_data_i;
    logic              stat_ack_o;
    logic              uart_tx_start_o;
    logic [7:0]        uart_tx_data_o;
    logic              uart_tx_int_i;
    logic              busy_o;
    logic [15:0]       frame_cnt_o;
    logic              timeout_err_o;

    uart_frame_sched #(
        .DATA_W      (DATA_W),
        .SYNC_SMP    (8'hA5),
        .SYNC_STAT   (8'h5A),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .fifo_data_i     (fifo_data_i),
        .stat_req_i      (stat_req_i),
        .stat_data_i     (stat_data_i),
        .stat_ack_o      (stat_ack_o),
        .uart_tx_start_o (uart_tx_start_o),
        .uart_tx_data_o  (uart_tx_data_o),
        .uart_tx_int_i   (uart_tx_int_i),
        .busy_o          (busy_o),
        .frame_cnt_o     (frame_cnt_o),
        .timeout_err_o   (timeout_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    int         start_cnt = 0;
    logic [7:0] last_byte = 8'd0;
    int         ack_cnt = 0;
    int         rd_cnt = 0;
    logic       tx_mute = 1'b0;
    logic [2:0] tx_cnt = 3'd0;

    // Sample FIFO model.
    logic [DATA_W-1:0] smp_mem [64];
    logic [7:0]        push_cnt = 8'd0;
    logic [7:0]        pop_cnt = 8'd0;
    assign fifo_empty_i = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en_o) begin
            fifo_data_i <= smp_mem[pop_cnt[5:0]];
            pop_cnt     <= pop_cnt + 8'd1;
            rd_cnt      <= rd_cnt + 1;
        end
        if (stat_ack_o) begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    // uart_tx model: byte done pulse 4 cycles after start unless muted.
    always @(posedge clk) begin
        uart_tx_int_i <= 1'b0;
        if (uart_tx_start_o) begin
            tx_cnt <= 3'd4;
        end else if (tx_cnt != 3'd0) begin
            tx_cnt <= tx_cnt - 3'd1;
            if (tx_cnt == 3'd1 && !tx_mute) begin
                uart_tx_int_i <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sample(input logic [DATA_W-1:0] v);
        smp_mem[push_cnt[5:0]] = v;
        push_cnt = push_cnt + 8'd1;
    endtask

    task automatic exp_frame(input logic [7:0] s, input logic [7:0] h, input logic [7:0] l);
        exp_q.push_back(s);
        exp_q.push_back(h);
        exp_q.push_back(l);
`ifdef SCHED_CHECKSUM_EN
        exp_q.push_back(s ^ h ^ l);
`endif
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy_o) && c < 300) begin
            @(negedge clk); #1;
            c++;
        end
        check({name, "_complete"}, 32'(c < 300), 32'd1);
    endtask

    // Scoreboard monitor: every start pulse must carry the next expected byte,
    // and the byte must still be held when uart_tx reports it done.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (uart_tx_start_o) begin
                start_cnt = start_cnt + 1;
                last_byte = uart_tx_data_o;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_start: got %02h, no byte expected", uart_tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(uart_tx_data_o), 32'(e));
                end
            end
            if (uart_tx_int_i && busy_o) begin
                check("tx_data_stable", 32'(uart_tx_data_o), 32'(last_byte));
            end
        end
    end

    // Run-time guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_a, t_b, base, s, t_idle;
        logic err_before;
        rst         = 1'b1;
        en          = 1'b0;
        stat_req_i  = 1'b0;
        stat_data_i = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              32'({fifo_rd_en_o, stat_ack_o, uart_tx_start_o, uart_tx_data_o,
                   busy_o, frame_cnt_o, timeout_err_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // 1: sample frame, latency and single read pulse.
        push_sample(13'h1ABC);
        exp_frame(8'hA5, 8'h1A, 8'hBC);
        base = rd_cnt;
        t_a = -1; t_b = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            if (fifo_rd_en_o && t_a < 0) t_a = c;
            if (uart_tx_start_o && t_b < 0) t_b = c;
        end
        check("smp_rd_latency", 32'(t_a), 32'd1);
        check("smp_start_latency", 32'(t_b), 32'd3);
        wait_done("smp_frame");
        check("smp_rd_pulses", 32'(rd_cnt - base), 32'd1);
        check("frame_cnt_1", 32'(frame_cnt_o), 32'd1);

        // 2: status frame, ack latency and single ack pulse.
        @(negedge clk);
        stat_data_i = 16'hBEEF;
        stat_req_i  = 1'b1;
        exp_frame(8'h5A, 8'hBE, 8'hEF);
        base = ack_cnt;
        t_a = -1; t_b = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            if (stat_ack_o && t_a < 0) begin
                t_a = c;
                stat_req_i = 1'b0;
            end
            if (uart_tx_start_o && t_b < 0) t_b = c;
        end
        check("stat_ack_latency", 32'(t_a), 32'd1);
        check("stat_start_latency", 32'(t_b), 32'd2);
        wait_done("stat_frame");
        check("stat_ack_pulses", 32'(ack_cnt - base), 32'd1);
        check("frame_cnt_2", 32'(frame_cnt_o), 32'd2);

        // 3: both pending -> SMP, STAT, SMP, STAT.
        @(negedge clk);
        push_sample(13'h1FFF);
        push_sample(13'h0000);
        stat_data_i = 16'h1234;
        stat_req_i  = 1'b1;
        exp_frame(8'hA5, 8'h1F, 8'hFF);
        exp_frame(8'h5A, 8'h12, 8'h34);
        exp_frame(8'hA5, 8'h00, 8'h00);
        exp_frame(8'h5A, 8'h00, 8'hFF);
        base = ack_cnt;
        for (int c = 0; c < 300 && stat_req_i; c++) begin
            @(negedge clk); #1;
            if (ack_cnt == base + 1) stat_data_i = 16'h00FF;
            if (ack_cnt == base + 2) stat_req_i = 1'b0;
        end
        wait_done("round_robin");
        check("frame_cnt_rr", 32'(frame_cnt_o), 32'd6);

        // 4: data 13'h0123 (checksum 8'h87 when enabled).
        @(negedge clk);
        push_sample(13'h0123);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h23);
`ifdef SCHED_CHECKSUM_EN
        exp_q.push_back(8'h87);
`endif
        wait_done("chk_frame");
        check("frame_cnt_chk", 32'(frame_cnt_o), 32'd7);

        // 5: uart_tx silent -> abort after 16 WAIT cycles.
        @(negedge clk);
        tx_mute = 1'b1;
        push_sample(13'h0005);
        exp_q.push_back(8'hA5);
        s = -1; t_idle = -1; err_before = 1'b1;
        for (int c = 1; c <= 40 && t_idle < 0; c++) begin
            @(negedge clk); #1;
            if (uart_tx_start_o && s < 0) s = c;
            if (s >= 0 && c == s + 16) err_before = timeout_err_o;
            if (s >= 0 && !busy_o) t_idle = c;
        end
        check("timeout_idle_at", 32'(t_idle - s), 32'd17);
        check("timeout_err_before", 32'(err_before), 32'd0);
        check("timeout_err_set", 32'(timeout_err_o), 32'd1);
        check("frame_cnt_abort", 32'(frame_cnt_o), 32'd7);
        repeat (6) @(negedge clk);
        tx_mute = 1'b0;
        push_sample(13'h0ABC);
        exp_frame(8'hA5, 8'h0A, 8'hBC);
        wait_done("after_timeout");
        check("frame_cnt_recover", 32'(frame_cnt_o), 32'd8);
        check("timeout_err_sticky", 32'(timeout_err_o), 32'd1);

        // 6: reset in WAIT of byte 2, then en=0 holds off a pending sample.
        @(negedge clk);
        push_sample(13'h0777);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h07);
        base = start_cnt;
        for (int c = 0; c < 40 && start_cnt < base + 2; c++) begin
            @(negedge clk); #1;
        end
        check("rst_reached_byte2", 32'(start_cnt - base), 32'd2);
        @(negedge clk);
        rst     = 1'b1;
        tx_mute = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_frame_outputs",
              32'({fifo_rd_en_o, stat_ack_o, uart_tx_start_o, uart_tx_data_o,
                   busy_o, frame_cnt_o, timeout_err_o}), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        push_sample(13'h0042);
        base = rd_cnt;
        t_a = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (busy_o) t_a++;
        end
        check("en_low_busy_cycles", 32'(t_a), 32'd0);
        check("en_low_rd_pulses", 32'(rd_cnt - base), 32'd0);
        check("rst_dropped_frame", 32'(exp_q.size()), 32'd0);
        tx_mute = 1'b0;
        en      = 1'b1;
        exp_frame(8'hA5, 8'h00, 8'h42);
        wait_done("en_resume");
        check("frame_cnt_after_rst", 32'(frame_cnt_o), 32'd1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
